// File: rtl/rtc_pkg.sv
// Shared RTC timestamp types and helpers.
// Timestamp word layout and latency compensation used by TSU/PPS blocks.
package rtc_pkg;

  localparam int NS_W      = 38;
  localparam int SEC_W     = 48;
  localparam int NS_FRAC_W = 8;

  typedef struct packed {
    logic [SEC_W-1:0] sec;
    logic [NS_W-1:0]  ns;
  } rtc_ts_t;

  // Subtract comp from a stamp, wrapping ns at modulo and
  // borrowing one second. The sum is taken one bit wider so
  // ns + modulo cannot overflow before comp is removed.
  function automatic rtc_ts_t ts_comp(
    input rtc_ts_t         ts,
    input logic [NS_W-1:0] comp,
    input logic [NS_W-1:0] modulo
  );
    rtc_ts_t       r;
    logic [NS_W:0] sum;
    r = ts;
    if (ts.ns >= comp) begin
      sum = {1'b0, ts.ns};
    end else begin
      sum   = {1'b0, ts.ns} + {1'b0, modulo};
      r.sec = ts.sec - SEC_W'(1);
    end
    // Result is below modulo, so the top bit is always zero.
    sum  = sum - {1'b0, comp};
    r.ns = sum[NS_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/rtc_ts_fifo.sv
// Synchronous show-ahead FIFO with registered fill level.
// Ports: wr_i/wdata_i write, rd_i pop, rdata_o head, empty/full/level, drop_o.
module rtc_ts_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          rd_i,
  output logic [W-1:0]  rdata_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [LW-1:0] level_o,
  output logic          drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PONE = (AW+1)'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          rd_ok, wr_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // A pop frees a slot in the same cycle, so full+rd+wr is lossless.
  assign rd_ok   = rd_i & ~empty_o;
  assign wr_ok   = wr_i & (~full_o | rd_ok);
  assign drop_o  = wr_i & ~wr_ok;

  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign level_o = level_q;

  always_comb begin
    wptr_d  = wr_ok ? wptr_q + PONE : wptr_q;
    rptr_d  = rd_ok ? rptr_q + PONE : rptr_q;
    level_d = level_q + LW'(wr_ok) - LW'(rd_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/rtc_ts_queue.sv
// Event timestamp unit: sync evt_in, capture RTC time on rising edge,
// remove sync latency, queue for reader. Ports: evt_*, time_*, comp_ns, q_*.
module rtc_ts_queue
  import rtc_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LW          = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              evt_in,
  input  logic              evt_en,
  input  logic [NS_W-1:0]   time_reg_ns,
  input  logic [SEC_W-1:0]  time_reg_sec,
  input  logic [NS_W-1:0]   time_acc_modulo,
  input  logic [NS_W-1:0]   comp_ns,
  input  logic              q_rd,
  output logic [NS_W-1:0]   q_ns,
  output logic [SEC_W-1:0]  q_sec,
  output logic              q_empty,
  output logic [LW-1:0]     q_level,
  output logic              q_ovf,
  input  logic              ovf_clr
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic    prev_q;
  logic    cap;
  logic    v1_q, v2_q;
  rtc_ts_t ts1_q, ts2_q;
  rtc_ts_t head;
  logic    q_full, drop;
  logic    ovf_q, ovf_d;

  assign cap = sync_q[SYNC_STAGES-1] & ~prev_q & evt_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      ts1_q  <= '0;
      ts2_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], evt_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      v1_q   <= cap;
      if (cap) ts1_q <= '{sec: time_reg_sec, ns: time_reg_ns};
      v2_q   <= v1_q;
      ts2_q  <= ts_comp(ts1_q, comp_ns, time_acc_modulo);
    end
  end

  rtc_ts_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(rtc_ts_t)),
    .LW    (LW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_i    (v2_q),
    .wdata_i (ts2_q),
    .rd_i    (q_rd),
    .rdata_o (head),
    .empty_o (q_empty),
    .full_o  (q_full),
    .level_o (q_level),
    .drop_o  (drop)
  );

  // Set has priority over clear.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr)       ovf_d = 1'b0;
    if (drop & q_full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign q_ovf = ovf_q;
  assign q_ns  = head.ns;
  assign q_sec = head.sec;

endmodule

// File: tb/tb_rtc_ts_queue.sv
// Self-checking bench for rtc_ts_queue (DEPTH=4).
// Randomized and directed captures against a queue-based model.
module tb_rtc_ts_queue;
  import rtc_pkg::*;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam logic [37:0] MOD = 38'h3B_9ACA_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          evt_in, evt_en, q_rd, ovf_clr;
  logic [37:0]   time_reg_ns, time_acc_modulo, comp_ns;
  logic [47:0]   time_reg_sec;
  logic [37:0]   q_ns;
  logic [47:0]   q_sec;
  logic          q_empty, q_ovf;
  logic [LW-1:0] q_level;

  int errors = 0;
  int checks = 0;

  rtc_ts_t mq[$];
  logic    movf;

  rtc_ts_queue #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .evt_in(evt_in), .evt_en(evt_en),
    .time_reg_ns(time_reg_ns), .time_reg_sec(time_reg_sec),
    .time_acc_modulo(time_acc_modulo), .comp_ns(comp_ns),
    .q_rd(q_rd), .q_ns(q_ns), .q_sec(q_sec), .q_empty(q_empty),
    .q_level(q_level), .q_ovf(q_ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic rtc_ts_t model(logic [63:0] ns, logic [63:0] sec,
                                    logic [63:0] comp);
    logic [63:0] e_ns, e_sec;
    rtc_ts_t r;
    if (ns >= comp) begin
      e_ns  = ns - comp;
      e_sec = sec;
    end else begin
      e_ns  = ns + {26'd0, MOD} - comp;
      e_sec = (sec == 0) ? 64'h0000_FFFF_FFFF_FFFF : sec - 1;
    end
    r.ns  = e_ns[37:0];
    r.sec = e_sec[47:0];
    return r;
  endfunction

  task automatic mpush(logic [37:0] ns, logic [47:0] sec);
    if (mq.size() < DEPTH) mq.push_back(model(64'(ns), 64'(sec), 64'(comp_ns)));
    else movf = 1'b1;
  endtask

  task automatic capture(logic [37:0] ns, logic [47:0] sec);
    time_reg_ns  = ns;
    time_reg_sec = sec;
    evt_in = 1'b1;
    repeat (3) tick();
    evt_in = 1'b0;
    repeat (2) tick();
    if (evt_en) mpush(ns, sec);
  endtask

  task automatic pop_check(string nm);
    rtc_ts_t e;
    checks++;
    if (mq.size() == 0) begin
      errors++;
      $display("FAIL %s: model queue unexpectedly empty", nm);
    end else begin
      e = mq.pop_front();
      if (q_empty !== 1'b0 || q_ns !== e.ns || q_sec !== e.sec) begin
        errors++;
        $display("FAIL %s: got empty=%b ns=%h sec=%h, exp ns=%h sec=%h",
                 nm, q_empty, q_ns, q_sec, e.ns, e.sec);
      end
    end
    q_rd = 1'b1;
    tick();
    q_rd = 1'b0;
  endtask

  task automatic check_state(string nm);
    checks++;
    if (q_level !== LW'(mq.size()) || q_empty !== (mq.size() == 0) ||
        q_ovf !== movf) begin
      errors++;
      $display("FAIL %s: got level=%0d empty=%b ovf=%b, exp level=%0d ovf=%b",
               nm, q_level, q_empty, q_ovf, mq.size(), movf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    check_state("reset_init");
    rst = 1'b0;
    tick();
    comp_ns = 38'h400;
    capture(38'h1234_0000, 48'd3);
    evt_in = 1'b1;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    mq.delete();
    movf = 1'b0;
    check_state("reset_mid");
    evt_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check_state("reset_after");
  endtask

  task automatic test_no_borrow();
    comp_ns      = 38'h400;
    time_reg_ns  = 38'h6400;
    time_reg_sec = 48'd5;
    evt_in = 1'b1;
    repeat (3) tick();
    evt_in = 1'b0;
    tick();
    checks++;
    if (q_empty !== 1'b1) begin
      errors++;
      $display("FAIL latency_early: got empty=%b exp 1", q_empty);
    end
    tick();
    checks++;
    if (q_empty !== 1'b0) begin
      errors++;
      $display("FAIL latency_on_time: got empty=%b exp 0", q_empty);
    end
    mpush(38'h6400, 48'd5);
    checks++;
    if (q_ns !== 38'h6000 || q_sec !== 48'd5) begin
      errors++;
      $display("FAIL no_borrow: got ns=%h sec=%h exp ns=6000 sec=5", q_ns, q_sec);
    end
    pop_check("no_borrow_pop");
    check_state("no_borrow_empty");
  endtask

  task automatic test_borrow();
    comp_ns = 38'h400;
    capture(38'h200, 48'd7);
    checks++;
    if (q_ns !== 38'h3B_9AC9_FE00 || q_sec !== 48'd6) begin
      errors++;
      $display("FAIL borrow: got ns=%h sec=%h exp ns=3b9ac9fe00 sec=6", q_ns, q_sec);
    end
    pop_check("borrow_pop");
    comp_ns = 38'h100;
    capture(38'h0, 48'd0);
    checks++;
    if (q_ns !== 38'h3B_9AC9_FF00 || q_sec !== 48'hFFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL sec_wrap: got ns=%h sec=%h exp ns=3b9ac9ff00 sec=ffffffffffff",
               q_ns, q_sec);
    end
    pop_check("sec_wrap_pop");
    check_state("borrow_empty");
  endtask

  task automatic test_overflow();
    comp_ns = 38'h400;
    for (int i = 0; i < 6; i++)
      capture(38'h10_0000 + 38'(i) * 38'h1000, 48'(100 + i));
    repeat (4) tick();
    check_state("ovf_full");
    for (int i = 0; i < 4; i++) pop_check("ovf_pop");
    check_state("ovf_drained");
    ovf_clr = 1'b1;
    movf    = 1'b0;
    tick();
    ovf_clr = 1'b0;
    check_state("ovf_clr");
    for (int i = 0; i < 4; i++)
      capture(38'h20_0000 + 38'(i) * 38'h1000, 48'(200 + i));
    check_state("refill");
    time_reg_ns  = 38'h30_0000;
    time_reg_sec = 48'd300;
    evt_in = 1'b1;
    repeat (3) tick();
    evt_in = 1'b0;
    tick();
    pop_check("full_rd_wr_pop");
    mpush(38'h30_0000, 48'd300);
    check_state("full_rd_wr");
    for (int i = 0; i < 4; i++) pop_check("full_rd_wr_drain");
    check_state("full_rd_wr_empty");
  endtask

  task automatic test_enable();
    comp_ns = 38'h0;
    evt_en  = 1'b0;
    for (int i = 0; i < 3; i++) capture(38'h5000 + 38'(i), 48'd1);
    repeat (4) tick();
    check_state("en_blocked");
    evt_en       = 1'b1;
    time_reg_ns  = 38'h7777;
    time_reg_sec = 48'd2;
    evt_in = 1'b1;
    repeat (3) tick();
    evt_en = 1'b0;
    evt_in = 1'b0;
    repeat (2) tick();
    mpush(38'h7777, 48'd2);
    repeat (3) tick();
    evt_en = 1'b1;
    pop_check("en_inflight");
    check_state("en_empty");
  endtask

  task automatic test_back_to_back();
    logic [37:0] prev;
    comp_ns      = 38'h10;
    time_reg_sec = 48'd9;
    for (int i = 0; i < 12; i++) begin
      time_reg_ns = 38'h1000 + 38'(i) * 38'h100;
      evt_in = (i < 8) && (i % 2 == 0);
      tick();
    end
    evt_in = 1'b0;
    repeat (6) tick();
    checks++;
    if (q_level !== LW'(4) || q_ovf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_level: got level=%0d ovf=%b exp 4 0", q_level, q_ovf);
    end
    prev = '0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (q_empty !== 1'b0 || q_sec !== 48'd9 ||
          (k > 0 && (q_ns <= prev || q_ns - prev !== 38'h200))) begin
        errors++;
        $display("FAIL b2b_order: k=%0d got ns=%h sec=%h prev=%h exp step 200",
                 k, q_ns, q_sec, prev);
      end
      prev = q_ns;
      q_rd = 1'b1;
      tick();
      q_rd = 1'b0;
    end
    check_state("b2b_empty");
  endtask

  task automatic test_random();
    logic [63:0] r;
    logic [37:0] ns, comp;
    logic [47:0] sec;
    for (int i = 0; i < 12; i++) begin
      r = {$urandom(), $urandom()};
      if (i % 2 == 0) begin
        comp = 38'($urandom_range(1, 32'hFFFF));
        ns   = 38'($urandom_range(0, 32'(comp) - 1));
      end else begin
        comp = 38'(r % 64'(MOD));
        ns   = 38'({$urandom(), $urandom()} % 64'(MOD));
      end
      sec = (i % 3 == 0) ? 48'd0 : {$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF;
      comp_ns = comp;
      capture(ns, sec);
      pop_check("random");
    end
    check_state("random_empty");
  endtask

  initial begin
    rst             = 1'b1;
    evt_in          = 1'b0;
    evt_en          = 1'b1;
    q_rd            = 1'b0;
    ovf_clr         = 1'b0;
    time_reg_ns     = '0;
    time_reg_sec    = '0;
    time_acc_modulo = MOD;
    comp_ns         = '0;
    movf            = 1'b0;
    test_reset();
    test_no_borrow();
    test_borrow();
    test_overflow();
    test_enable();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
